simd_loop_sequencer: RTL and testbench

Front-end sequencer for the SIMD iterator/address-generation stage. Accepts the decoded instruction stream, captures the body of a single-level hardware loop into a local buffer, and replays it the programmed number of times. Drives `in_single_loop` so the iterator stage writes back base+stride after every loop-body access. Pass-through for non-loop instructions.

---
 rtl/simd_pkg.sv | 27 ++
 rtl/simd_loop_body_buf.sv | 33 +++
 rtl/simd_loop_sequencer.sv | 179 +++++++++++++++++
 tb/tb_simd_loop_sequencer.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/simd_pkg.sv
// ============================================================================
// simd_pkg : shared constants and types for the SIMD loop sequencer
// Revision : 1.0
// ============================================================================
`default_nettype none

package simd_pkg;

    localparam logic [3:0] LOOP_OPCODE = 4'b1001;

    // Instruction field positions within the 32-bit decoded word
    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 28;
    localparam int LEN_MSB = 23;
    localparam int LEN_LSB = 16;
    localparam int CNT_MSB = 15;
    localparam int CNT_LSB = 0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FILL   = 2'd1,
        ST_REPLAY = 2'd2
    } seq_state_t;

endpackage

`default_nettype wire

// File: rtl/simd_loop_body_buf.sv
// ============================================================================
// simd_loop_body_buf : loop-body register file, 1 sync write / 1 comb read
// Revision : 1.0
// ============================================================================
`default_nettype none

module simd_loop_body_buf #(
    parameter int INST_WIDTH = 32,
    parameter int BODY_DEPTH = 16,
    parameter int PTR_W      = 4
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [PTR_W-1:0]      waddr,
    input  logic [INST_WIDTH-1:0] wdata,
    input  logic [PTR_W-1:0]      raddr,
    output logic [INST_WIDTH-1:0] rdata
);

    // Contents are intentionally not reset; only captured entries are ever read.
    logic [INST_WIDTH-1:0] mem [BODY_DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

`default_nettype wire

// File: rtl/simd_loop_sequencer.sv
// ============================================================================
// simd_loop_sequencer : captures a single-level loop body and replays it N times
// Revision : 1.0
// ============================================================================
`default_nettype none

module simd_loop_sequencer #(
    parameter int         INST_WIDTH  = 32,
    parameter int         BODY_DEPTH  = 16,
    parameter int         ITER_WIDTH  = 16,
    parameter logic [3:0] LOOP_OPCODE = simd_pkg::LOOP_OPCODE
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [INST_WIDTH-1:0] inst_in,
    input  logic                  inst_in_valid,
    output logic                  inst_in_ready,
    output logic [INST_WIDTH-1:0] inst_out,
    output logic                  inst_out_valid,
    input  logic                  inst_out_ready,
    output logic                  in_single_loop,
    output logic                  loop_done,
    output logic                  loop_error
);

    import simd_pkg::*;

    localparam int PTR_W = (BODY_DEPTH > 1) ? $clog2(BODY_DEPTH) : 1;

    seq_state_t            state;
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      len_m1;
    logic [ITER_WIDTH-1:0] n_cnt;
    logic [ITER_WIDTH-1:0] iter;
    logic                  out_last;

    logic [3:0]            opc;
    logic [7:0]            len_f;
    logic [15:0]           cnt_f;
    logic                  is_loop;
    logic                  slot_free;
    logic                  in_xfer;
    logic                  out_xfer;
    logic                  fill_we;
    logic                  fill_last;
    logic                  rep_last_entry;
    logic                  rep_last_iter;
    logic [INST_WIDTH-1:0] rd_data;

    assign opc            = inst_in[OPC_MSB:OPC_LSB];
    assign len_f          = inst_in[LEN_MSB:LEN_LSB];
    assign cnt_f          = inst_in[CNT_MSB:CNT_LSB];
    assign is_loop        = (opc == LOOP_OPCODE);

    assign slot_free      = !inst_out_valid || inst_out_ready;
    assign inst_in_ready  = (state != ST_REPLAY) && slot_free;
    assign in_xfer        = inst_in_valid && inst_in_ready;
    assign out_xfer       = inst_out_valid && inst_out_ready;

    assign fill_we        = (state == ST_FILL) && in_xfer && !is_loop;
    assign fill_last      = (wr_ptr == len_m1);
    assign rep_last_entry = (rd_ptr == len_m1);
    assign rep_last_iter  = (iter == (n_cnt - ITER_WIDTH'(1)));

    simd_loop_body_buf #(
        .INST_WIDTH (INST_WIDTH),
        .BODY_DEPTH (BODY_DEPTH),
        .PTR_W      (PTR_W)
    ) u_body_buf (
        .clk   (clk),
        .we    (fill_we),
        .waddr (wr_ptr),
        .wdata (inst_in),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= ST_IDLE;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            len_m1         <= '0;
            n_cnt          <= '0;
            iter           <= '0;
            out_last       <= 1'b0;
            inst_out       <= '0;
            inst_out_valid <= 1'b0;
            in_single_loop <= 1'b0;
            loop_done      <= 1'b0;
            loop_error     <= 1'b0;
        end else begin
            // out_last marks the word whose transfer completes the whole loop
            loop_done  <= out_xfer && out_last;
            loop_error <= 1'b0;
            if (out_xfer) begin
                inst_out_valid <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (in_xfer) begin
                        if (is_loop) begin
                            if (len_f == 8'd0) begin
                                state <= ST_IDLE;
                            end else if (32'(len_f) > BODY_DEPTH) begin
                                loop_error <= 1'b1;
                            end else begin
                                len_m1 <= PTR_W'(len_f - 8'd1);
                                n_cnt  <= ITER_WIDTH'(cnt_f);
                                wr_ptr <= '0;
                                state  <= ST_FILL;
                            end
                        end else begin
                            inst_out       <= inst_in;
                            inst_out_valid <= 1'b1;
                            in_single_loop <= 1'b0;
                            out_last       <= 1'b0;
                        end
                    end
                end

                ST_FILL: begin
                    if (in_xfer) begin
                        if (is_loop) begin
                            loop_error <= 1'b1;
                        end else begin
                            // A zero-count loop still captures its body but emits nothing
                            if (n_cnt != '0) begin
                                inst_out       <= inst_in;
                                inst_out_valid <= 1'b1;
                                in_single_loop <= 1'b1;
                                out_last       <= fill_last && (n_cnt == ITER_WIDTH'(1));
                            end
                            if (fill_last) begin
                                if (n_cnt <= ITER_WIDTH'(1)) begin
                                    state <= ST_IDLE;
                                end else begin
                                    state  <= ST_REPLAY;
                                    iter   <= ITER_WIDTH'(1);
                                    rd_ptr <= '0;
                                end
                            end else begin
                                wr_ptr <= wr_ptr + 1'b1;
                            end
                        end
                    end
                end

                ST_REPLAY: begin
                    if (slot_free) begin
                        inst_out       <= rd_data;
                        inst_out_valid <= 1'b1;
                        in_single_loop <= 1'b1;
                        out_last       <= rep_last_entry && rep_last_iter;
                        if (rep_last_entry) begin
                            rd_ptr <= '0;
                            if (rep_last_iter) begin
                                state <= ST_IDLE;
                            end else begin
                                iter <= iter + 1'b1;
                            end
                        end else begin
                            rd_ptr <= rd_ptr + 1'b1;
                        end
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_simd_loop_sequencer.sv
// ============================================================================
// tb_simd_loop_sequencer : scoreboard bench with a queue-based loop model
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_simd_loop_sequencer;

    logic        clk;
    logic        reset;
    logic [31:0] inst_in;
    logic        inst_in_valid;
    logic        inst_in_ready;
    logic [31:0] inst_out;
    logic        inst_out_valid;
    logic        inst_out_ready = 1'b1;
    logic        in_single_loop;
    logic        loop_done;
    logic        loop_error;

    simd_loop_sequencer #(
        .INST_WIDTH  (32),
        .BODY_DEPTH  (16),
        .ITER_WIDTH  (16),
        .LOOP_OPCODE (4'b1001)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .inst_in        (inst_in),
        .inst_in_valid  (inst_in_valid),
        .inst_in_ready  (inst_in_ready),
        .inst_out       (inst_out),
        .inst_out_valid (inst_out_valid),
        .inst_out_ready (inst_out_ready),
        .in_single_loop (in_single_loop),
        .loop_done      (loop_done),
        .loop_error     (loop_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] w;
        bit          isl;
        bit          last;
    } exp_t;

    exp_t        exp_q[$];
    int          dq[$];
    int          eq[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          rdy_mode = 0;
    bit          mon_en = 1'b0;
    bit          prev_stall = 1'b0;
    logic [31:0] prev_word;
    bit          prev_isl;

    // Reference model: loop semantics expressed as queue expansion
    int          m_fill = 0;
    int          m_len = 0;
    int          m_cnt = 0;
    logic [31:0] m_body[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic model_accept(input logic [31:0] w, output bit err);
        int len;
        int cnt;
        len = int'(w[23:16]);
        cnt = int'(w[15:0]);
        err = 1'b0;
        if (m_fill == 0) begin
            if (w[31:28] == 4'b1001) begin
                if (len > 16) begin
                    err = 1'b1;
                end else if (len > 0) begin
                    m_fill = 1;
                    m_len  = len;
                    m_cnt  = cnt;
                    m_body.delete();
                end
            end else begin
                exp_q.push_back('{w: w, isl: 1'b0, last: 1'b0});
            end
        end else if (w[31:28] == 4'b1001) begin
            err = 1'b1;
        end else begin
            m_body.push_back(w);
            if (m_cnt != 0)
                exp_q.push_back('{w: w, isl: 1'b1,
                                  last: (m_cnt == 1) && (m_body.size() == m_len)});
            if (m_body.size() == m_len) begin
                for (int it = 1; it < m_cnt; it++)
                    for (int j = 0; j < m_len; j++)
                        exp_q.push_back('{w: m_body[j], isl: 1'b1,
                                          last: (it == m_cnt - 1) && (j == m_len - 1)});
                m_fill = 0;
            end
        end
    endtask

    task automatic send(input logic [31:0] w);
        bit err;
        int waited;
        bit ok;
        waited = 0;
        ok = 1'b0;
        inst_in       = w;
        inst_in_valid = 1'b1;
        while (!ok) begin
            @(negedge clk);
            if (inst_in_ready) begin
                ok = 1'b1;
            end else if (++waited > 1000) begin
                checks++;
                failures++;
                $display("FAIL in_ready_timeout word=%08h", w);
                break;
            end
        end
        if (ok) begin
            model_accept(w, err);
            if (err) eq.push_back(cyc + 1);
        end
        @(posedge clk);
        #1;
        inst_in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || dq.size() != 0 || eq.size() != 0) && n < 3000) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (n >= 3000) begin
            failures++;
            $display("FAIL drain_timeout pending_outputs=%0d required=0", exp_q.size());
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic idle_gap(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [31:0] loop_w(input int l, input int n);
        return {4'b1001, 4'h3, l[7:0], n[15:0]};
    endfunction

    function automatic logic [31:0] rand_plain();
        logic [31:0] w;
        w = $urandom;
        if (w[31:28] == 4'b1001) w[31:28] = 4'h0;
        return w;
    endfunction

    // Downstream ready pattern generator
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       inst_out_ready = 1'b1;
                1:       inst_out_ready = !inst_out_ready;
                default: inst_out_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // Monitor: pops the scoreboard on each output transfer
    always @(negedge clk) begin : mon
        exp_t e;
        bit   exp_done;
        bit   exp_err;
        if (!reset || !mon_en) begin
            prev_stall = 1'b0;
        end else begin
            exp_done = (dq.size() != 0) && (dq[0] == cyc);
            if (exp_done) void'(dq.pop_front());
            if (exp_done || loop_done) check("loop_done", loop_done, exp_done);
            exp_err = (eq.size() != 0) && (eq[0] == cyc);
            if (exp_err) void'(eq.pop_front());
            if (exp_err || loop_error) check("loop_error", loop_error, exp_err);

            if (prev_stall) begin
                check("hold_valid", inst_out_valid, 1'b1);
                check("hold_word", inst_out, prev_word);
                check("hold_isl", in_single_loop, prev_isl);
            end

            if (inst_out_valid && inst_out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_output got=%08h required=none", inst_out);
                end else begin
                    e = exp_q.pop_front();
                    check("out_word", inst_out, e.w);
                    check("out_isl", in_single_loop, e.isl);
                    if (e.last) dq.push_back(cyc + 1);
                end
            end
            prev_stall = inst_out_valid && !inst_out_ready;
            prev_word  = inst_out;
            prev_isl   = in_single_loop;
        end
    end

    initial begin
        logic [31:0] w;
        reset         = 1'b0;
        inst_in       = '0;
        inst_in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out", inst_out, 32'h0);
        check("rst_valid", inst_out_valid, 1'b0);
        check("rst_isl", in_single_loop, 1'b0);
        check("rst_done", loop_done, 1'b0);
        check("rst_err", loop_error, 1'b0);
        check("rst_in_ready", inst_in_ready, 1'b1);
        reset  = 1'b1;
        mon_en = 1'b1;
        idle_gap(2);

        // Pass-through with one-cycle latency
        for (int i = 0; i < 3; i++) begin
            w = rand_plain();
            send(w);
            check("pt_latency_valid", inst_out_valid, 1'b1);
            check("pt_latency_word", inst_out, w);
        end
        drain();

        // L=3, N=4; input must be blocked once replay starts
        send(loop_w(3, 4));
        send(32'h1000_00A0);
        send(32'h2000_00B0);
        send(32'h3000_00C0);
        check("in_ready_replay", inst_in_ready, 1'b0);
        drain();

        // Backpressure toggling, L=2, N=3
        rdy_mode = 1;
        send(loop_w(2, 3));
        send(32'h4000_0AAA);
        send(32'h5000_0BBB);
        drain();
        rdy_mode = 0;

        // Boundary counts: N=0 then N=1 with a full-depth body
        send(loop_w(2, 0));
        send(rand_plain());
        send(rand_plain());
        send(loop_w(16, 1));
        for (int i = 0; i < 16; i++) send(rand_plain());
        drain();

        // Rejected loops: oversize, then a LOOP arriving during fill
        send(loop_w(17, 2));
        send(rand_plain());
        send(loop_w(2, 2));
        send(32'h6000_0001);
        send(loop_w(3, 3));
        send(32'h7000_0002);
        send(32'h8000_0003);
        drain();

        // Randomised mix under varying downstream behaviour
        for (int i = 0; i < 160; i++) begin
            if (i % 32 == 0) rdy_mode = $urandom_range(0, 2);
            if ($urandom_range(0, 99) < 18)
                send(loop_w($urandom_range(0, 18), $urandom_range(0, 4)));
            else
                send(rand_plain());
            idle_gap($urandom_range(0, 1));
        end
        drain();
        rdy_mode = 0;

        // Asynchronous reset in the middle of a long replay
        send(loop_w(3, 50));
        send(rand_plain());
        send(rand_plain());
        send(rand_plain());
        repeat (5) @(posedge clk);
        #3;
        mon_en = 1'b0;
        reset  = 1'b0;
        #1;
        check("midrst_valid", inst_out_valid, 1'b0);
        check("midrst_isl", in_single_loop, 1'b0);
        check("midrst_out", inst_out, 32'h0);
        check("midrst_in_ready", inst_in_ready, 1'b1);
        exp_q.delete();
        dq.delete();
        eq.delete();
        m_fill = 0;
        m_body.delete();
        repeat (2) @(posedge clk);
        #1;
        reset  = 1'b1;
        mon_en = 1'b1;
        w = rand_plain();
        send(w);
        check("post_rst_valid", inst_out_valid, 1'b1);
        check("post_rst_word", inst_out, w);
        check("post_rst_isl", in_single_loop, 1'b0);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
